rand_kind_checker: RTL and testbench
====================================

Name: rand_kind_checker

Overview:
- Downstream consumer for the odd/even/one-hot random-number generator stage.
- Accepts a stream of DATA_W-bit values, each tagged with the class it claims to be (odd, even, one-hot).
- Checks each value against its class and emits a registered per-beat pass/fail result.
- Keeps saturating per-class pass counters, an error counter and a first-error capture, read by the testbench scoreboard.

Parameters:
DATA_W, 8, width of checked value
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream value valid
in_ready  output  1  checker can accept a value this cycle
in_data  input  DATA_W  value under check
in_kind  input  2  claimed class: 0 odd, 1 even, 2 one-hot, 3 reserved
clear  input  1  synchronous clear of statistics and capture
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_pass  output  1  1 = value matched its class
res_data  output  DATA_W  echoed value
res_kind  output  2  echoed class
odd_cnt  output  CNT_W  passing odd values
even_cnt  output  CNT_W  passing even values
onehot_cnt  output  CNT_W  passing one-hot values
err_cnt  output  CNT_W  failing values, any class
err_sticky  output  1  set on first failure, held until clear/reset
first_err_data  output  DATA_W  value of first failure
first_err_kind  output  2  class of first failure

Behaviour:

Reset and handshake:
- Reset: asynchronous on rst_n low. Every output listed above resets to 0, except in_ready, which is 1 while rst_n is high and the result slot is free.
- Transfer in: a beat is accepted when in_valid && in_ready.
- in_ready is combinational: in_ready = !res_valid || res_ready. The result slot is a single register, so throughput is one beat per cycle when res_ready is held high.
- Latency: the result appears on res_* on the cycle after acceptance, with res_valid = 1.
- res_* holds stable while res_valid && !res_ready. res_valid clears after res_ready unless a new beat is accepted in the same cycle.

Check rules, purely combinational on in_data/in_kind:
- odd passes iff in_data[0] = 1.
- even passes iff in_data[0] = 0. Zero is a passing even value.
- one-hot passes iff popcount(in_data) = 1. Zero fails and all-ones fails.
- kind 3 always fails.

Statistics, updated on the acceptance cycle (visible the cycle after):
- A passing beat increments its class counter.
- A failing beat increments err_cnt.
- All counters saturate at 2^CNT_W-1 and never wrap.
- On a failure while err_sticky = 0: set err_sticky, capture first_err_data and first_err_kind. Later failures leave the capture unchanged.

clear:
- clear = 1 zeroes all counters, err_sticky, first_err_data and first_err_kind on the next edge.
- When clear coincides with an accepted beat, clear wins for statistics and capture: the beat is not counted. Its result is still produced on res_* normally.
- clear does not affect res_valid or the result slot.

Reset mid-operation:
- An in-flight result is dropped and res_valid goes 0 immediately.
- Counters and capture go to 0.
- No beat is accepted while rst_n is low.

Decomposition:
- Shared package rand_pkg holds:
  - kind encoding constants KIND_ODD=2'd0, KIND_EVEN=2'd1, KIND_ONEHOT=2'd2, KIND_RSVD=2'd3, so the generator and the checker share one encoding.
  - A pure function is_onehot(value) built on popcount.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated four times.
- The check logic stays inline.

Test Plan:
1. Reset release with res_ready = 1; send odd 8'h07, even 8'h0A, one-hot 8'h10 back-to-back -> three results on consecutive cycles, each res_pass = 1, first one cycle after acceptance; odd_cnt = even_cnt = onehot_cnt = 1, err_cnt = 0, err_sticky = 0.
2. Failure capture: send one-hot 8'h00, then odd 8'h04, then kind 3 with 8'h01 -> res_pass = 0 for all three; err_cnt = 3, err_sticky = 1, first_err_data = 8'h00, first_err_kind = 2. One-hot 8'hFF also fails.
3. Backpressure: hold res_ready = 0, present two beats (8'h03 odd, 8'h06 even) -> first accepted, in_ready = 0 afterward, res_data stable at 8'h03. Raise res_ready for one cycle -> 8'h06 accepted that same cycle, appears next cycle; no beat lost or duplicated.
4. Saturation: with CNT_W = 4, send 20 passing even values -> even_cnt stops at 15 and stays 15; other counters remain 0.
5. clear coincident with accepted failing beat 8'h02 odd -> result res_pass = 0 is emitted, but next cycle err_cnt = 0 and err_sticky = 0. The following failure is then captured as first error.
6. Assert rst_n low while res_valid = 1 with counters non-zero -> res_valid, all counters and err_sticky read 0 within the same cycle, without waiting for a clock edge. After release, in_ready = 1.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared kind encoding and class helpers for the odd/even/one-hot generator and checker.
package rand_pkg;

  localparam logic [1:0] KIND_ODD    = 2'd0;
  localparam logic [1:0] KIND_EVEN   = 2'd1;
  localparam logic [1:0] KIND_ONEHOT = 2'd2;
  localparam logic [1:0] KIND_RSVD   = 2'd3;

  // Callers zero-extend narrower values; extra zero bits do not change the count.
  function automatic int popcount(input logic [31:0] value);
    int count;
    count = 0;
    for (int i = 0; i < 32; i++) count += int'(value[i]);
    return count;
  endfunction

  function automatic logic is_onehot(input logic [31:0] value);
    return popcount(value) == 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/rand_kind_checker.sv
// Checks each tagged value against its claimed class, registers a per-beat verdict and keeps statistics.
module rand_kind_checker
  import rand_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_kind,
  input  logic              clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_pass,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_kind,
  output logic [CNT_W-1:0]  odd_cnt,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  onehot_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  output logic [DATA_W-1:0] first_err_data,
  output logic [1:0]        first_err_kind
);

  logic              vld_p1;
  logic              pass_p1;
  logic [DATA_W-1:0] data_p1;
  logic [1:0]        kind_p1;
  logic              accept_p0;
  logic              pass_p0;
  logic              count_p0;

  assign in_ready  = rst_n && (!vld_p1 || res_ready);
  assign accept_p0 = in_valid && in_ready;
  // A beat coinciding with clear still produces a result but is never counted.
  assign count_p0  = accept_p0 && !clear;

  always_comb begin
    pass_p0 = 1'b0;
    case (in_kind)
      KIND_ODD:    pass_p0 = in_data[0];
      KIND_EVEN:   pass_p0 = !in_data[0];
      KIND_ONEHOT: pass_p0 = is_onehot(32'(in_data));
      KIND_RSVD:   pass_p0 = 1'b0;
      default:     pass_p0 = 1'b0;
    endcase
  end

  // ---- p0 -> p1: single-entry result slot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pass_p1 <= 1'b0;
      data_p1 <= '0;
      kind_p1 <= '0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      pass_p1 <= pass_p0;
      data_p1 <= in_data;
      kind_p1 <= in_kind;
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_pass  = pass_p1;
  assign res_data  = data_p1;
  assign res_kind  = kind_p1;

  // ---- p0 -> p1: statistics and first-error capture ----
  sat_counter #(.CNT_W(CNT_W)) u_odd_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(count_p0 && pass_p0 && in_kind == KIND_ODD), .cnt(odd_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_even_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(count_p0 && pass_p0 && in_kind == KIND_EVEN), .cnt(even_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_onehot_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(count_p0 && pass_p0 && in_kind == KIND_ONEHOT), .cnt(onehot_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear),
    .inc(count_p0 && !pass_p0), .cnt(err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky     <= 1'b0;
      first_err_data <= '0;
      first_err_kind <= '0;
    end else if (clear) begin
      err_sticky     <= 1'b0;
      first_err_data <= '0;
      first_err_kind <= '0;
    end else if (count_p0 && !pass_p0 && !err_sticky) begin
      err_sticky     <= 1'b1;
      first_err_data <= in_data;
      first_err_kind <= in_kind;
    end
  end

endmodule

// File: tb/tb_rand_kind_checker.sv
// Bench for rand_kind_checker: vector table, directed corner sequences and randomized traffic against a cycle model.
module tb_rand_kind_checker;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, clear, res_valid, res_ready, res_pass, err_sticky;
  logic [DATA_W-1:0] in_data, res_data, first_err_data;
  logic [1:0]        in_kind, res_kind, first_err_kind;
  logic [CNT_W-1:0]  odd_cnt, even_cnt, onehot_cnt, err_cnt;

  always #5 clk = ~clk;

  rand_kind_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_kind(in_kind), .clear(clear),
    .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
    .res_data(res_data), .res_kind(res_kind), .odd_cnt(odd_cnt),
    .even_cnt(even_cnt), .onehot_cnt(onehot_cnt), .err_cnt(err_cnt),
    .err_sticky(err_sticky), .first_err_data(first_err_data),
    .first_err_kind(first_err_kind)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: result slot, counters indexed by kind (3 = errors), first-error capture.
  logic       m_rv, m_rp, m_sticky;
  logic [7:0] m_rd, m_fd;
  logic [1:0] m_rk, m_fk;
  int         m_cnt[4];

  typedef struct {
    logic [7:0] data;
    logic [1:0] kind;
    logic       exp_pass;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_pass(input logic [7:0] d, input logic [1:0] k);
    int v;
    v = int'(d);
    case (k)
      2'd0:    return (v % 2) == 1;
      2'd1:    return (v % 2) == 0;
      2'd2:    return v != 0 && (v & (v - 1)) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_rv = 0; m_rp = 0; m_rd = 0; m_rk = 0;
    m_sticky = 0; m_fd = 0; m_fk = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic check_state();
    check("res_valid", res_valid, m_rv);
    if (m_rv) begin
      check("res_data", res_data, m_rd);
      check("res_kind", res_kind, m_rk);
      check("res_pass", res_pass, m_rp);
    end
    check("odd_cnt", odd_cnt, m_cnt[0]);
    check("even_cnt", even_cnt, m_cnt[1]);
    check("onehot_cnt", onehot_cnt, m_cnt[2]);
    check("err_cnt", err_cnt, m_cnt[3]);
    check("err_sticky", err_sticky, m_sticky);
    check("first_err_data", first_err_data, m_fd);
    check("first_err_kind", first_err_kind, m_fk);
  endtask

  // One clock: drive at posedge+1, check in_ready at negedge, advance model at posedge, check at posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] k,
                       input logic rr, input logic clr);
    logic acc, p;
    in_valid = v; in_data = d; in_kind = k; res_ready = rr; clear = clr;
    @(negedge clk);
    check("in_ready", in_ready, !m_rv || rr);
    acc = v && (!m_rv || rr);
    p   = exp_pass(d, k);
    @(posedge clk);
    if (acc) begin
      m_rv = 1; m_rd = d; m_rk = k; m_rp = p;
    end else if (rr) begin
      m_rv = 0;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_sticky = 0; m_fd = 0; m_fk = 0;
    end else if (acc) begin
      if (p) begin
        if (m_cnt[k] < MAXC) m_cnt[k]++;
      end else begin
        if (m_cnt[3] < MAXC) m_cnt[3]++;
        if (!m_sticky) begin
          m_sticky = 1; m_fd = d; m_fk = k;
        end
      end
    end
    #1;
    in_valid = 0; clear = 0;
    check_state();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h07, 2'd0, 1'b1};
    vecs[1] = '{8'h0A, 2'd1, 1'b1};
    vecs[2] = '{8'h10, 2'd2, 1'b1};
    vecs[3] = '{8'h00, 2'd2, 1'b0};
    vecs[4] = '{8'h04, 2'd0, 1'b0};
    vecs[5] = '{8'h01, 2'd3, 1'b0};
    vecs[6] = '{8'hFF, 2'd2, 1'b0};
    vecs[7] = '{8'h00, 2'd1, 1'b1};
    vecs[8] = '{8'h80, 2'd2, 1'b1};
    vecs[9] = '{8'hFE, 2'd0, 1'b0};

    rst_n = 0; in_valid = 0; in_data = 0; in_kind = 0; clear = 0; res_ready = 1;
    model_reset();
    #2;
    check("reset_in_ready", in_ready, 0);
    check_state();
    @(negedge clk); rst_n = 1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back table with res_ready held high; checkpoints after the pass and fail groups.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].data, vecs[i].kind, 1'b1, 1'b0);
      check("tbl_pass", res_pass, vecs[i].exp_pass);
      if (i == 2) begin
        check("t1_odd", odd_cnt, 1);
        check("t1_even", even_cnt, 1);
        check("t1_onehot", onehot_cnt, 1);
        check("t1_err", err_cnt, 0);
        check("t1_sticky", err_sticky, 0);
      end
      if (i == 5) begin
        check("t2_err", err_cnt, 3);
        check("t2_sticky", err_sticky, 1);
        check("t2_fdata", first_err_data, 8'h00);
        check("t2_fkind", first_err_kind, 2'd2);
      end
    end
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

    // Backpressure: second beat waits until res_ready rises, then is taken that same cycle.
    cycle(1'b1, 8'h03, 2'd0, 1'b0, 1'b0);
    check("bp_data0", res_data, 8'h03);
    cycle(1'b1, 8'h06, 2'd1, 1'b0, 1'b0);
    check("bp_hold", res_data, 8'h03);
    cycle(1'b1, 8'h06, 2'd1, 1'b0, 1'b0);
    check("bp_hold2", res_data, 8'h03);
    cycle(1'b1, 8'h06, 2'd1, 1'b1, 1'b0);
    check("bp_data1", res_data, 8'h06);
    check("bp_valid1", res_valid, 1);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check("bp_drain", res_valid, 0);

    // Saturation of even_cnt after a clear.
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(2 * i), 2'd1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check("sat_even", even_cnt, 15);
    check("sat_odd", odd_cnt, 0);
    check("sat_err", err_cnt, 0);

    // clear coinciding with an accepted failing beat.
    cycle(1'b1, 8'h02, 2'd0, 1'b1, 1'b1);
    check("clr_res_pass", res_pass, 0);
    check("clr_res_valid", res_valid, 1);
    check("clr_err", err_cnt, 0);
    check("clr_sticky", err_sticky, 0);
    cycle(1'b1, 8'h05, 2'd1, 1'b1, 1'b0);
    check("clr_next_sticky", err_sticky, 1);
    check("clr_next_fdata", first_err_data, 8'h05);
    check("clr_next_fkind", first_err_kind, 2'd1);

    // Asynchronous reset with a pending result and non-zero counters.
    cycle(1'b1, 8'h09, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 0;
    #1;
    check("ar_res_valid", res_valid, 0);
    check("ar_odd", odd_cnt, 0);
    check("ar_even", even_cnt, 0);
    check("ar_err", err_cnt, 0);
    check("ar_sticky", err_sticky, 0);
    check("ar_fdata", first_err_data, 0);
    check("ar_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk); rst_n = 1; res_ready = 1;
    #1;
    check("ar_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check_state();

    // Randomized traffic with random backpressure and occasional clear.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      logic [1:0] k;
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) d = 8'(1 << $urandom_range(0, 7));
      else d = 8'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), d, k, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
